spike_window_classifier: RTL

SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

---
 rtl/spike_window_classifier.sv | 107 ++++++++++
 1 files changed

// File: rtl/spike_window_classifier.sv
// spike_window_classifier: counts per-channel spikes over a fixed window, then scans for the highest-count channel.
// Ports:
//   clk_i, rst_i (async, active-high)  clock and reset
//   start_i                             opens a count window (honoured only in IDLE)
//   spike_i[NUM_CH]                     one spike bit per channel, sampled during COUNT
//   ready_i                             consumer accepts the result (honoured only in DONE)
//   busy_o                              high in COUNT, SCAN and DONE
//   counts_o                            channel c count at [c*WIDTH_P +: WIDTH_P]
//   overflow_o[NUM_CH]                  sticky per-channel saturation flags
//   valid_o, winner_o, winner_count_o, tie_o   classification result
module spike_window_classifier #(
    parameter int NUM_CH     = 10,
    parameter int WIDTH_P    = 8,
    parameter int WINDOW_LEN = 100,
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [NUM_CH-1:0]           spike_i,
    input  logic                        ready_i,
    output logic                        busy_o,
    output logic [NUM_CH*WIDTH_P-1:0]   counts_o,
    output logic [NUM_CH-1:0]           overflow_o,
    output logic                        valid_o,
    output logic [IDX_W-1:0]            winner_o,
    output logic [WIDTH_P-1:0]          winner_count_o,
    output logic                        tie_o
);
    localparam int WC_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;
    state_t               state_q;
    logic [WC_W-1:0]      win_q;
    logic [IDX_W-1:0]     scan_q;
    logic [WIDTH_P-1:0]   counts_q [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q;
    logic [IDX_W-1:0]     winner_q;
    logic [WIDTH_P-1:0]   max_q;
    logic                 tie_q;
    logic                 valid_q;
    logic [WIDTH_P-1:0]   cur_d;
    assign cur_d = counts_q[scan_q];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            win_q    <= '0;
            scan_q   <= '0;
            ovf_q    <= '0;
            winner_q <= '0;
            max_q    <= '0;
            tie_q    <= 1'b0;
            valid_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) counts_q[c] <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= COUNT;
                    win_q   <= '0;
                    ovf_q   <= '0;
                    for (int c = 0; c < NUM_CH; c++) counts_q[c] <= '0;
                end
                COUNT: begin
                    // Saturate at all-ones and latch the sticky overflow flag instead of wrapping.
                    for (int c = 0; c < NUM_CH; c++)
                        if (spike_i[c]) begin
                            if (counts_q[c] == '1) ovf_q[c] <= 1'b1;
                            else counts_q[c] <= counts_q[c] + 1'b1;
                        end
                    win_q <= win_q + 1'b1;
                    if (win_q == WC_W'(WINDOW_LEN - 1)) begin
                        state_q <= SCAN;
                        scan_q  <= '0;
                    end
                end
                SCAN: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (scan_q == '0 || cur_d > max_q) begin
                        winner_q <= scan_q;
                        max_q    <= cur_d;
                        tie_q    <= 1'b0;
                    end else if (cur_d == max_q) begin
                        tie_q <= 1'b1;
                    end
                    scan_q <= scan_q + 1'b1;
                    if (scan_q == IDX_W'(NUM_CH - 1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: if (ready_i) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign counts_o[g*WIDTH_P +: WIDTH_P] = counts_q[g];
    end
    assign busy_o         = state_q != IDLE;
    assign overflow_o     = ovf_q;
    assign valid_o        = valid_q;
    assign winner_o       = winner_q;
    assign winner_count_o = max_q;
    assign tie_o          = tie_q;
endmodule
